alu_exec_unit: RTL and testbench

Multi-cycle execution unit that consumes the 4-bit ALU control code and the two register operands and produces the datapath result. It sits directly downstream of the ALU control decoder, in the execute stage of the CPU. Logic, add/sub and shift operations finish in one cycle. `MUL` runs as an iterative shift-add multiply over `WIDTH` cycles, and the unit signals busy/done to the control unit while it runs.

---
 rtl/alu_exec_unit.sv | 144 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : execute-stage unit; single-cycle logic/add/shift, iterative MUL
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_cnt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] c_op_and = 4'b0000;
   localparam logic [3:0] c_op_or  = 4'b0010;
   localparam logic [3:0] c_op_xor = 4'b0011;
   localparam logic [3:0] c_op_add = 4'b0100;
   localparam logic [3:0] c_op_sub = 4'b1100;
   localparam logic [3:0] c_op_sll = 4'b0001;
   localparam logic [3:0] c_op_srl = 4'b0110;
   localparam logic [3:0] c_op_mul = 4'b0111;
   localparam logic [SHW-1:0] c_cnt_last = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW-1:0]     r_cnt;
   logic [WIDTH-1:0]   r_result, r_result_hi;
   logic               r_zero, r_overflow;

   logic               w_accept;
   logic [WIDTH-1:0]   w_sum, w_diff, w_res;
   logic               w_ovf;
   logic [WIDTH:0]     w_upper;
   logic [2*WIDTH-1:0] w_acc_nxt;

   assign w_accept = start && (r_state == S_IDLE);
   assign w_sum    = a + b;
   assign w_diff   = a - b;

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (alu_cnt)
         c_op_and: w_res = a & b;
         c_op_or:  w_res = a | b;
         c_op_xor: w_res = a ^ b;
         c_op_add: begin
            w_res = w_sum;
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_sub: begin
            w_res = w_diff;
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         c_op_sll: w_res = a << b[SHW-1:0];
         c_op_srl: w_res = a >> b[SHW-1:0];
         default:  w_res = '0;
      endcase
   end

   // Shift-add step: multiplier sits in the low half and is consumed LSB first;
   // the carry of the upper-half add re-enters at the MSB on the right shift.
   assign w_upper   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_nxt = {w_upper, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = (alu_cnt == c_op_mul) ? S_MUL : S_DONE;
         S_MUL:   if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand     <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_zero      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            if (alu_cnt != c_op_mul) begin
               r_result    <= w_res;
               r_result_hi <= '0;
               r_zero      <= (w_res == '0);
               r_overflow  <= w_ovf;
            end
         end
         if (r_state == S_MUL) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_last) begin
               r_result    <= w_acc_nxt[WIDTH-1:0];
               r_result_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
               r_zero      <= (w_acc_nxt == '0);
               r_overflow  <= 1'b0;
            end
         end
      end
   end

   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign zero      = r_zero;
   assign overflow  = r_overflow;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : directed, table-driven checks of alu_exec_unit (WIDTH=16)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_cnt;
   logic [15:0] a, b;
   logic [15:0] result, result_hi;
   logic        zero, overflow, busy, done;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(16), .SHW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .alu_cnt   (alu_cnt),
      .a         (a),
      .b         (b),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .overflow  (overflow),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [15:0] hi;
      logic        z;
      logic        o;
      logic [5:0]  lat;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns the cycle (1 = right after accept) in which
   // done was seen, or -1 on timeout, plus the number of busy cycles.
   task automatic do_op(input logic [3:0] op, input logic [15:0] xa, input logic [15:0] xb,
                        output int lat, output int nbusy);
      for (int k = 0; k < 40 && busy; k++) @(negedge clk);
      start = 1'b1; alu_cnt = op; a = xa; b = xb;
      @(posedge clk);
      lat = -1; nbusy = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start   = 1'b0;
            a       = 16'($urandom);
            b       = 16'($urandom);
            alu_cnt = 4'($urandom);
         end
         if (busy) nbusy++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat, nbusy, dcount;

      vecs[0]  = '{4'b0000, 16'h00FF, 16'h0F0F, 16'h000F, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[1]  = '{4'b0010, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[2]  = '{4'b0011, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[3]  = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 6'd1};
      vecs[4]  = '{4'b1100, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd1};
      vecs[5]  = '{4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd1};
      vecs[6]  = '{4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 6'd1};
      vecs[7]  = '{4'b0001, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[8]  = '{4'b0110, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[9]  = '{4'b0001, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[10] = '{4'b0110, 16'hF0F0, 16'h0004, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 6'd1};
      vecs[11] = '{4'b0111, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 6'd17};
      vecs[12] = '{4'b0111, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd17};
      vecs[13] = '{4'b0111, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b0, 1'b0, 6'd17};
      vecs[14] = '{4'b0111, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0, 6'd17};
      vecs[15] = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 1'b0, 6'd1};
      vecs[16] = '{4'b0100, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1, 6'd1};

      rst_n = 1'b0; start = 1'b0; alu_cnt = 4'd0; a = 16'd0; b = 16'd0;
      #1;
      chk("reset_outputs", {result, result_hi, zero, overflow, busy, done}, 36'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy);
         chk($sformatf("v%0d_latency", i), lat, 32'(vecs[i].lat));
         chk($sformatf("v%0d_busy_cycles", i), nbusy, 32'(vecs[i].lat));
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_result_hi", i), result_hi, vecs[i].hi);
         chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
         chk($sformatf("v%0d_overflow", i), overflow, vecs[i].o);
         @(negedge clk);
         chk($sformatf("v%0d_hold", i), result, vecs[i].res);
      end

      // MUL 0x00FF*0x0101 with an XOR start pulsed mid-run
      @(negedge clk);
      start = 1'b1; alu_cnt = 4'b0111; a = 16'h00FF; b = 16'h0101;
      @(posedge clk);
      dcount = 0; lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin
            start = 1'b1; alu_cnt = 4'b0011; a = 16'h1111; b = 16'h2222;
         end
         if (k == 4) start = 1'b0;
         if (done) begin
            dcount++;
            if (lat < 0) begin
               lat = k;
               chk("ign_mul_result", result, 16'hFFFF);
               chk("ign_mul_result_hi", result_hi, 16'h0000);
            end
         end
      end
      chk("ign_done_count", dcount, 32'd1);
      chk("ign_mul_latency", lat, 32'd17);
      do_op(4'b0011, 16'hAAAA, 16'hFFFF, lat, nbusy);
      chk("xor_after_ign", result, 16'h5555);
      chk("xor_after_ign_latency", lat, 32'd1);

      // Reset in the middle of a MUL
      @(negedge clk);
      start = 1'b1; alu_cnt = 4'b0111; a = 16'hFFFF; b = 16'hFFFF;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      chk("pre_reset_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midmul_reset_outputs", {result, result_hi, zero, overflow, busy, done}, 36'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("no_done_after_reset", dcount, 32'd0);
      do_op(4'b0000, 16'h00FF, 16'h0F0F, lat, nbusy);
      chk("post_reset_and", result, 16'h000F);
      chk("post_reset_and_latency", lat, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
